wb_arbiter2: RTL and testbench
==============================

// Module: wb_arbiter2
// PURPOSE
//  Two-master Wishbone arbiter sharing one 16-bit slave port (unified code/data RAM) between
//  the J1 CPU (m0, holds cyc/stb high continuously) and a DMA/debug master (m1).
//  Per-transfer arbitration with bounded quotas so neither master starves; slave-ack timeout.
//  Sits between j1_wb and the memory/IO decoder at top level.
// PARAMETERS
//  M0_QUOTA      4    max back-to-back m0 transfers while m1 is requesting (>=1)
//  M1_QUOTA      8    max back-to-back m1 transfers while m0 is requesting (>=1)
//  WAIT_TIMEOUT  255  cycles of stb without slave ack before forced completion (>=2, <=255)
// PORTS
//  clk          in   1     clock
//  reset_n      in   1     asynchronous reset, active low
//  m0           if   -     if_wb.slave: cyc, stb, we, adr[15:0], dat_m[15:0], dat_s[15:0], ack
//  m1           if   -     if_wb.slave, same signals
//  s            if   -     if_wb.master to shared slave, same signals
//  timeout_clr  in   1     pulse: clear sticky timeout flag
//  timeout      out  1     sticky: a forced completion occurred
//  grant        out  2     one-hot current owner {m1,m0}; 2'b00 = none
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, grant=00, counters 0, timeout=0; s.cyc/stb/we=0,
//   s.adr=0, s.dat_m=0, m0.ack=m1.ack=0, m0.dat_s=m1.dat_s=0. Reset mid-transfer abandons it.
//  req0 = m0.cyc & m0.stb; req1 = m1.cyc & m1.stb.
//  States (registered): IDLE, OWN0, OWN1 (enum arb_state_t).
//  Datapath: combinational mux from owner to s (cyc, stb, we, adr, dat_m); s.dat_s fanned to
//   both masters; s.ack routed only to owner, gated by owner stb; non-owner ack=0 (stalls it).
//   IDLE drives s.cyc=s.stb=0.
//  Latency: IDLE->grant takes 1 cycle; while owning, zero added latency (pure pass-through).
//  Transitions (evaluated each rising edge; "done" = ack delivered to owner this cycle):
//   IDLE: req0 -> OWN0 (m0 wins tie); else req1 -> OWN1; else stay.
//   OWN0: done & req1 & cnt==M0_QUOTA-1 -> OWN1, cnt=0; done otherwise -> stay, cnt++ (sat.);
//         !req0 (between transfers) -> OWN1 if req1 else IDLE, cnt=0.
//   OWN1: done & req0 & cnt==M1_QUOTA-1 -> OWN0, cnt=0; done -> stay, cnt++ (sat.);
//         !m1.cyc -> OWN0 if req0 else IDLE, cnt=0. m1 keeps grant while cyc high, stb low.
//  Quota count only advances while the other master requests; else cnt held at 0.
//  Grant never changes while owner has stb high and no done (no mid-transfer switch).
//  Timeout: wcnt (8 bit) counts cycles with s.stb & !s.ack; cleared on done or grant change.
//   At wcnt==WAIT_TIMEOUT-1: owner gets ack=1, dat_s=ARB_TIMEOUT_DAT (16'hDEAD), s.stb forced 0
//   that cycle; timeout<=1; treated as done for transitions.
//  timeout: set on forced completion, cleared by timeout_clr; simultaneous set+clr -> set wins.
//  Slave ack arriving when owner stb=0 is dropped (not forwarded).
// STRUCTURE
//  j1_types gains: arb_state_t {IDLE, OWN0, OWN1}; ARB_TIMEOUT_DAT = 16'hDEAD.
//  One sub-module: wb_arb_timer (wait counter + sticky flag; inputs stb, ack, clr; outputs
//   expire, timeout). Arbiter FSM, quota counter and muxes stay in wb_arbiter2.
// TESTING
//  1 reset: assert reset_n=0 mid-m1 transfer -> next cycle s.stb=0, grant=00, acks 0.
//  2 m0 only, slave 0-wait ack: req0 from cycle 0 -> grant=01 at cycle 1, m0.ack every cycle,
//    m0 adr seen on s.adr unchanged; m1.ack stays 0.
//  3 contention, M0_QUOTA=4, M1_QUOTA=8, both stb high, 0-wait slave: grant sequence
//    4 m0 acks, 8 m1 acks, 4 m0 acks...; no ack to non-owner; no cycle lost between bursts.
//  4 m1 drops cyc after 3 transfers with m0 requesting -> grant=01 next cycle, cnt restarts.
//  5 slave never acks, WAIT_TIMEOUT=255: owner ack with dat_s=16'hDEAD at 255th stb cycle,
//    timeout=1 next cycle; timeout_clr pulse -> 0; set+clr same cycle -> 1.
//  6 IDLE tie: req0 and req1 rise same cycle -> grant=01; m1 served after M0_QUOTA acks.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_arbiter2_pkg;

    localparam int ADR_W = 16;
    localparam int DAT_W = 16;

    // Read data returned to a master whose transfer was force-completed.
    localparam logic [DAT_W-1:0] ARB_TIMEOUT_DAT = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_arbiter2_if.sv
// Wishbone classic bus bundle (16-bit address and data).
// Latency: n/a (wiring only).
// Backpressure: slave holds ack low to stall the master's strobe.
// master modport: drives cyc/stb/we/adr/dat_m, receives dat_s/ack.
// slave modport:  receives cyc/stb/we/adr/dat_m, drives dat_s/ack.
interface wb_arbiter2_if;
    logic                                cyc;
    logic                                stb;
    logic                                we;
    logic [wb_arbiter2_pkg::ADR_W-1:0]   adr;
    logic [wb_arbiter2_pkg::DAT_W-1:0]   dat_m;
    logic [wb_arbiter2_pkg::DAT_W-1:0]   dat_s;
    logic                                ack;

    modport master (output cyc, stb, we, adr, dat_m, input dat_s, ack);
    modport slave  (input cyc, stb, we, adr, dat_m, output dat_s, ack);
endinterface

// File: rtl/wb_arb_timer.sv
// Slave wait watchdog: counts strobe cycles without ack and flags a forced completion.
// Latency: expire is combinational from the registered wait count; timeout is registered.
// Backpressure: none; it only observes the granted strobe and the slave ack.
// Ports: i_stb owner strobe, i_ack slave ack, i_restart grant change, i_clr clear flag,
//        o_expire force-complete this cycle, o_timeout sticky forced-completion flag.
module wb_arb_timer #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_stb,
    input  logic i_ack,
    input  logic i_restart,
    input  logic i_clr,
    output logic o_expire,
    output logic o_timeout
);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    logic [7:0] r_wcnt;
    logic       r_timeout;
    logic       w_expire;

    // The cycle the count reaches the limit is itself the last waited cycle.
    assign w_expire  = i_stb & (r_wcnt == WAIT_LAST);
    assign o_expire  = w_expire;
    assign o_timeout = r_timeout;

    // The limit is at most 254, so the 8-bit count never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt <= '0;
        end else if (i_restart | w_expire | (i_stb & i_ack)) begin
            r_wcnt <= '0;
        end else if (i_stb) begin
            r_wcnt <= r_wcnt + 8'd1;
        end
    end

    // A new forced completion outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
        end else if (i_clr) begin
            r_timeout <= 1'b0;
        end
    end
endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter (CPU m0, DMA/debug m1) onto one shared slave with quotas.
// Latency: 1 cycle from IDLE to grant; zero added latency while a master owns the bus.
// Backpressure: non-owner sees ack=0 and stalls; owner sees slave ack or a forced timeout ack.
// Ports: clk, reset_n (async, active low); m0/m1 master-facing buses; s shared slave bus;
//        timeout_clr clears the sticky timeout; grant is one-hot owner {m1,m0}.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int M0_QUOTA     = 4,
    parameter int M1_QUOTA     = 8,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    wb_arbiter2_if.slave  m0,
    wb_arbiter2_if.slave  m1,
    wb_arbiter2_if.master s,
    input  logic          timeout_clr,
    output logic          timeout,
    output logic [1:0]    grant
);
    localparam int QMAX  = (M0_QUOTA > M1_QUOTA) ? M0_QUOTA : M1_QUOTA;
    localparam int CNT_W = $clog2(QMAX) + 1;
    localparam logic [CNT_W-1:0] Q0_LAST = CNT_W'(M0_QUOTA - 1);
    localparam logic [CNT_W-1:0] Q1_LAST = CNT_W'(M1_QUOTA - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_req0;
    logic             w_req1;
    logic             w_own_stb;
    logic             w_done;
    logic             w_expire;

    assign w_req0    = m0.cyc & m0.stb;
    assign w_req1    = m1.cyc & m1.stb;
    assign w_own_stb = ((r_state == OWN0) & m0.stb) | ((r_state == OWN1) & m1.stb);
    // A slave ack only counts while the owner is strobing; stray acks are dropped.
    assign w_done    = w_own_stb & (s.ack | w_expire);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    wb_arb_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_stb     (w_own_stb),
        .i_ack     (s.ack),
        .i_restart (w_state_nxt != r_state),
        .i_clr     (timeout_clr),
        .o_expire  (w_expire),
        .o_timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The quota count only runs while the other master is waiting; otherwise it sits at 0.
    // A strobed owner without done keeps the grant, so a transfer is never split.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_req0) begin
                    w_state_nxt = OWN0;
                end else if (w_req1) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (w_done) begin
                    if (w_req1 && (r_cnt == Q0_LAST)) begin
                        w_state_nxt = OWN1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_req1 ? w_cnt_inc : '0;
                    end
                end else if (!w_req0) begin
                    w_state_nxt = w_req1 ? OWN1 : IDLE;
                    w_cnt_nxt   = '0;
                end else if (!w_req1) begin
                    w_cnt_nxt = '0;
                end
            end
            OWN1: begin
                if (w_done) begin
                    if (w_req0 && (r_cnt == Q1_LAST)) begin
                        w_state_nxt = OWN0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_req0 ? w_cnt_inc : '0;
                    end
                end else if (!m1.cyc) begin
                    // m1 may idle its strobe inside a cycle and still keep the bus.
                    w_state_nxt = w_req0 ? OWN0 : IDLE;
                    w_cnt_nxt   = '0;
                end else if (!w_req0) begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        grant    = 2'b00;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.dat_m  = '0;
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        m0.dat_s = '0;
        m1.dat_s = '0;
        case (r_state)
            OWN0: begin
                grant    = 2'b01;
                s.cyc    = m0.cyc;
                s.stb    = m0.stb & ~w_expire;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.dat_m  = m0.dat_m;
                m0.ack   = w_done;
                m0.dat_s = w_expire ? ARB_TIMEOUT_DAT : s.dat_s;
                m1.dat_s = s.dat_s;
            end
            OWN1: begin
                grant    = 2'b10;
                s.cyc    = m1.cyc;
                s.stb    = m1.stb & ~w_expire;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.dat_m  = m1.dat_m;
                m1.ack   = w_done;
                m1.dat_s = w_expire ? ARB_TIMEOUT_DAT : s.dat_s;
                m0.dat_s = s.dat_s;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
`timescale 1ns/1ps
module tb_wb_arbiter2;
    import wb_arbiter2_pkg::*;

    localparam int M0Q = 4;
    localparam int M1Q = 8;
    localparam int WT  = 255;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       timeout_clr;
    logic       timeout;
    logic [1:0] grant;

    wb_arbiter2_if m0_if ();
    wb_arbiter2_if m1_if ();
    wb_arbiter2_if s_if ();

    wb_arbiter2 #(
        .M0_QUOTA     (M0Q),
        .M1_QUOTA     (M1Q),
        .WAIT_TIMEOUT (WT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .timeout_clr (timeout_clr),
        .timeout     (timeout),
        .grant       (grant)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stimulus held by the bench for both masters and the slave.
    logic        mc[2], ms[2], mw[2];
    logic [15:0] ma[2], md[2];
    logic        sack;
    logic [15:0] sdat;
    logic        clr;

    // Reference model state: who owns the bus, how many transfers in a row it has
    // had while the other side waited, and how long the current strobe has waited.
    int   m_owner;
    int   m_streak;
    int   m_waited;
    logic m_tflag;
    logic pend[2];

    typedef struct {
        logic       m0_req;
        logic       m1_cyc;
        logic       m1_stb;
        logic       s_ack;
        logic [1:0] g;
        logic       a0;
        logic       a1;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] snap();
        return {grant, m0_if.ack, m1_if.ack, s_if.cyc, s_if.stb, s_if.we, s_if.adr,
                s_if.dat_m, m0_if.dat_s, m1_if.dat_s, timeout};
    endfunction

    task automatic apply();
        m0_if.cyc = mc[0]; m0_if.stb = ms[0]; m0_if.we = mw[0]; m0_if.adr = ma[0]; m0_if.dat_m = md[0];
        m1_if.cyc = mc[1]; m1_if.stb = ms[1]; m1_if.we = mw[1]; m1_if.adr = ma[1]; m1_if.dat_m = md[1];
        s_if.ack = sack; s_if.dat_s = sdat; timeout_clr = clr;
    endtask

    task automatic set_m(input int i, input logic c, input logic b, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        mc[i] = c; ms[i] = b; mw[i] = w; ma[i] = a; md[i] = d;
    endtask

    task automatic add(input int n, input logic r0, input logic c1, input logic b1, input logic ak,
                       input logic [1:0] g, input logic a0, input logic a1);
        vec_t v;
        v.m0_req = r0; v.m1_cyc = c1; v.m1_stb = b1; v.s_ack = ak;
        v.g = g; v.a0 = a0; v.a1 = a1;
        repeat (n) tbl.push_back(v);
    endtask

    // Waits for m0's ack, counting cycles in which m0 held the grant.
    task automatic wait_m0_ack(output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (grant == 2'b01) n++;
            if (m0_if.ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int quota_of(input int o);
        return (o == 0) ? M0Q : M1Q;
    endfunction

    // Predicts this cycle's outputs from the arbitration rules, compares, then advances.
    task automatic model_cycle(input int cyc);
        logic        req[2];
        logic        ack[2];
        logic [15:0] d[2];
        logic [1:0]  g;
        logic        scyc, sstb, swe, expire, done;
        logic [15:0] sadr, sdm;
        int          o, nxt;
        o = m_owner;
        req[0] = mc[0] & ms[0];
        req[1] = mc[1] & ms[1];
        ack[0] = 1'b0; ack[1] = 1'b0; d[0] = '0; d[1] = '0;
        g = 2'b00; scyc = 1'b0; sstb = 1'b0; swe = 1'b0; sadr = '0; sdm = '0;
        expire = 1'b0; done = 1'b0;
        if (o >= 0) begin
            expire = ms[o] && (m_waited == WT - 1);
            done   = ms[o] && (sack || expire);
            g      = (o == 0) ? 2'b01 : 2'b10;
            scyc   = mc[o];
            sstb   = ms[o] && !expire;
            swe    = mw[o];
            sadr   = ma[o];
            sdm    = md[o];
            ack[o] = done;
            d[0]   = sdat;
            d[1]   = sdat;
            if (expire) d[o] = ARB_TIMEOUT_DAT;
        end
        check($sformatf("rand_cycle%0d", cyc), snap(),
              {g, ack[0], ack[1], scyc, sstb, swe, sadr, sdm, d[0], d[1], m_tflag});

        nxt = o;
        if (o < 0) begin
            nxt = req[0] ? 0 : (req[1] ? 1 : -1);
            m_streak = 0;
        end else if (done) begin
            if (req[1-o]) begin
                m_streak++;
                if (m_streak == quota_of(o)) begin
                    nxt = 1 - o;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else if ((o == 0) ? !req[0] : !mc[1]) begin
            nxt = req[1-o] ? 1 - o : -1;
            m_streak = 0;
        end else if (!req[1-o]) begin
            m_streak = 0;
        end
        if (nxt != o || done) m_waited = 0;
        else if (o >= 0 && ms[o]) m_waited++;
        if (expire) m_tflag = 1'b1;
        else if (clr) m_tflag = 1'b0;
        m_owner = nxt;
        pend[0] = ms[0] && !ack[0];
        pend[1] = ms[1] && !ack[1];
    endtask

    initial begin
        int   n;
        logic ok;

        // Reset state, with a stray slave ack and live read data on the bus.
        reset_n = 1'b0;
        set_m(0, 0, 0, 0, 16'h0, 16'h0);
        set_m(1, 0, 0, 0, 16'h0, 16'h0);
        sack = 1'b1; sdat = 16'h5A5A; clr = 1'b0;
        apply();
        @(negedge clk);
        @(negedge clk);
        check("reset_state", snap(), 72'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Tie from IDLE, quota alternation, m1 dropping cyc, then back to IDLE.
        add(1, 1, 1, 1, 1, 2'b00, 0, 0);
        add(4, 1, 1, 1, 1, 2'b01, 1, 0);
        add(8, 1, 1, 1, 1, 2'b10, 0, 1);
        add(4, 1, 1, 1, 1, 2'b01, 1, 0);
        add(3, 1, 1, 1, 1, 2'b10, 0, 1);
        add(1, 1, 0, 0, 1, 2'b10, 0, 0);
        add(1, 1, 0, 0, 1, 2'b01, 1, 0);
        add(4, 1, 1, 1, 1, 2'b01, 1, 0);
        add(1, 1, 1, 1, 1, 2'b10, 0, 1);
        add(1, 0, 0, 0, 1, 2'b10, 0, 0);
        add(1, 0, 0, 0, 1, 2'b00, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            set_m(0, tbl[i].m0_req, tbl[i].m0_req, 1'b0, 16'h1000 + 16'(i), 16'h0);
            set_m(1, tbl[i].m1_cyc, tbl[i].m1_stb, 1'b1, 16'h2000 + 16'(i), 16'h0);
            sack = tbl[i].s_ack;
            apply();
            @(negedge clk);
            check($sformatf("vec%0d", i), {grant, m0_if.ack, m1_if.ack},
                  {tbl[i].g, tbl[i].a0, tbl[i].a1});
        end

        // Reset asserted while m1 owns the bus with a transfer outstanding.
        @(posedge clk); #1;
        set_m(1, 1, 1, 1, 16'h3333, 16'h4444);
        sack = 1'b0; sdat = 16'hBEEF;
        apply();
        @(posedge clk); #1;
        @(negedge clk);
        check("own1_before_reset", grant, 2'b10);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("reset_mid_m1", snap(), 72'h0);
        @(posedge clk); #1;
        set_m(1, 0, 0, 0, 16'h0, 16'h0);
        apply();
        reset_n = 1'b1;

        // Slave never acks: forced completion, sticky flag, clear, set-beats-clear.
        @(posedge clk); #1;
        set_m(0, 1, 1, 0, 16'h0ABC, 16'h0);
        sack = 1'b0; sdat = 16'h1234;
        apply();
        wait_m0_ack(n, ok);
        check("timeout_fire", {ok, 16'(n), m0_if.dat_s, m1_if.dat_s, s_if.stb, timeout},
              {1'b1, 16'd255, 16'hDEAD, 16'h1234, 1'b0, 1'b0});
        @(posedge clk); #1;
        set_m(0, 0, 0, 0, 16'h0, 16'h0);
        apply();
        @(negedge clk);
        check("timeout_sticky", timeout, 1'b1);
        @(posedge clk); #1;
        clr = 1'b1; apply();
        @(posedge clk); #1;
        clr = 1'b0; apply();
        @(negedge clk);
        check("timeout_clr", timeout, 1'b0);
        @(posedge clk); #1;
        set_m(0, 1, 1, 0, 16'h0ABD, 16'h0);
        clr = 1'b1;
        apply();
        wait_m0_ack(n, ok);
        check("timeout_refire", {ok, 16'(n)}, {1'b1, 16'd255});
        @(posedge clk); #1;
        set_m(0, 0, 0, 0, 16'h0, 16'h0);
        apply();
        @(negedge clk);
        check("timeout_set_wins", timeout, 1'b1);
        clr = 1'b0; apply();

        // Randomised traffic against the reference model.
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_owner = -1; m_streak = 0; m_waited = 0; m_tflag = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!pend[0]) begin
                ms[0] = ($urandom_range(0, 3) != 0);
                set_m(0, ms[0] | 1'($urandom_range(0, 1)), ms[0], 1'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom));
            end
            if (!pend[1]) begin
                mc[1] = ($urandom_range(0, 4) != 0);
                set_m(1, mc[1], mc[1] & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom));
            end
            sack = 1'($urandom_range(0, 1));
            sdat = 16'($urandom);
            clr  = ($urandom_range(0, 15) == 0);
            apply();
            @(negedge clk);
            model_cycle(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
